// File: rtl/bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : bus_pkg                                                    |
// | Shared state encoding, mode constants and default widths for the     |
// | serial bus master/slave ports.                                       |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package bus_pkg;

  // Default widths shared with slave_port
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_TIMEOUT    = 64;

  // Transfer direction as carried on dmode/mmode
  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    ADDR  = 3'd2,
    WDATA = 3'd3,
    RWAIT = 3'd4,
    RDATA = 3'd5,
    DONE  = 3'd6
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_shift_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : serial_shift_reg                                           |
// | Parallel-load / LSB-first shift-out register that also shifts serial |
// | data in at the top, with a bit counter and a last-bit flag.          |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module serial_shift_reg #(
  parameter int WIDTH    = 12,
  parameter int RD_WIDTH = 8,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic [WIDTH-1:0]    load_data_i,
  input  logic                shift_i,
  input  logic                serial_i,
  input  logic [CNT_W-1:0]    last_idx_i,
  output logic                serial_o,
  output logic                last_o,
  output logic [RD_WIDTH-2:0] rd_part_o
);

  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt_q;

  // Load restarts the bit count; each shift moves one bit out of bit 0 and one in at the top
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      data_q <= load_data_i;
      cnt_q  <= '0;
    end else if (shift_i) begin
      data_q <= {serial_i, data_q[WIDTH-1:1]};
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

  // cnt_q is the index of the bit currently on the wire
  assign serial_o  = data_q[0];
  assign last_o    = (cnt_q == last_idx_i);
  // Bits received so far sit at the top; the final bit is merged by the caller
  assign rd_part_o = data_q[WIDTH-1 -: RD_WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/master_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : master_port                                                |
// | Serial bus initiator: takes one parallel request from a device,      |
// | arbitrates for the bus, sends address/write data LSB first and       |
// | collects read data, with an optional read timeout.                   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module master_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dvalid,
  output logic                  dready,
  input  logic                  dmode,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic [DATA_WIDTH-1:0] dwdata,
  output logic [DATA_WIDTH-1:0] drdata,
  output logic                  ddone,
  output logic                  derr,
  output logic                  mbreq,
  input  logic                  mbgrant,
  output logic                  mwdata,
  input  logic                  mrdata,
  output logic                  mmode,
  output logic                  mvalid,
  input  logic                  svalid,
  input  logic                  sready,
  input  logic                  ssplit
);

  localparam int SR_W  = max_int(ADDR_WIDTH, DATA_WIDTH);
  localparam int CNT_W = (SR_W > 1) ? $clog2(SR_W) : 1;
  localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] drdata_q, drdata_d;
  logic [TO_W-1:0]       tcnt_q, tcnt_d;

  logic                  sr_load;
  logic [SR_W-1:0]       sr_load_data;
  logic                  sr_shift;
  logic                  sr_serial_in;
  logic [CNT_W-1:0]      sr_last_idx;
  logic                  sr_serial_out;
  logic                  sr_last;
  logic [DATA_WIDTH-2:0] sr_rd_part;
  logic                  busy;

  // One register serves the address, write-data and read-data phases in turn
  serial_shift_reg #(
    .WIDTH    (SR_W),
    .RD_WIDTH (DATA_WIDTH),
    .CNT_W    (CNT_W)
  ) u_sr (
    .clk         (clk),
    .rst         (rst),
    .load_i      (sr_load),
    .load_data_i (sr_load_data),
    .shift_i     (sr_shift),
    .serial_i    (sr_serial_in),
    .last_idx_i  (sr_last_idx),
    .serial_o    (sr_serial_out),
    .last_o      (sr_last),
    .rd_part_o   (sr_rd_part)
  );

  assign sr_last_idx = (state_q == ADDR) ? CNT_W'(ADDR_WIDTH - 1) : CNT_W'(DATA_WIDTH - 1);

  // State and request/result registers; reset is immediate, even mid-transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= MODE_READ;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      drdata_q <= '0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      drdata_q <= drdata_d;
      tcnt_q   <= tcnt_d;
    end
  end

  // Next-state, shift-register control and timeout bookkeeping
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    drdata_d     = drdata_q;
    tcnt_d       = '0;
    sr_load      = 1'b0;
    sr_load_data = '0;
    sr_shift     = 1'b0;
    sr_serial_in = 1'b0;

    case (state_q)
      IDLE: begin
        err_d = 1'b0;
        if (dvalid) begin
          mode_d                        = dmode;
          wdata_d                       = dwdata;
          sr_load                       = 1'b1;
          sr_load_data[ADDR_WIDTH-1:0]  = daddr;
          state_d                       = REQ;
        end
      end
      REQ: begin
        if (mbgrant && sready) begin
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (sr_last) begin
          // Reload for the next phase so there is no gap cycle on writes
          sr_load = 1'b1;
          if (mode_q == MODE_WRITE) begin
            sr_load_data[DATA_WIDTH-1:0] = wdata_q;
            state_d                      = WDATA;
          end else begin
            state_d = RWAIT;
          end
        end else begin
          sr_shift = 1'b1;
        end
      end
      WDATA: begin
        if (sr_last) begin
          state_d = DONE;
        end else begin
          sr_shift = 1'b1;
        end
      end
      RWAIT: begin
        if (svalid) begin
          sr_shift     = 1'b1;
          sr_serial_in = mrdata;
          state_d      = RDATA;
        end else if (!ssplit && (TIMEOUT != 0)) begin
          // A split clears the count (default above); only idle waiting counts
          tcnt_d = tcnt_q + TO_W'(1);
          if (tcnt_q == TO_W'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      RDATA: begin
        if (svalid) begin
          if (sr_last) begin
            drdata_d = {mrdata, sr_rd_part};
            state_d  = DONE;
          end else begin
            sr_shift     = 1'b1;
            sr_serial_in = mrdata;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy   = (state_q == REQ) || (state_q == ADDR) || (state_q == WDATA) ||
                  (state_q == RWAIT) || (state_q == RDATA);
  assign dready = (state_q == IDLE);
  assign mbreq  = busy;
  assign mmode  = busy & mode_q;
  assign mvalid = (state_q == ADDR) || (state_q == WDATA);
  assign mwdata = mvalid & sr_serial_out;
  assign ddone  = (state_q == DONE);
  assign derr   = (state_q == DONE) & err_q;
  assign drdata = drdata_q;

endmodule
`default_nettype wire

// File: doc/master_port.md
Name: master_port

Overview:
- Serial-bus initiator: the counterpart of the slave-side port.
- Accepts one parallel read/write request from a local device.
- Requests the bus from the arbiter, then serialises address and write data onto the bus. For reads it deserialises the returned data.
- Sits between a master device (CPU/DMA stub) and the bus arbiter/mux, mirroring the slave's swdata/srdata/smode/mvalid/svalid/sready/ssplit signalling.

Parameters:
- ADDR_WIDTH, 12: address bits sent serially.
- DATA_WIDTH, 8: data bits per transfer.
- TIMEOUT, 64: max cycles waiting for svalid on a read; 0 disables the timeout.

Ports:
- clk  input  1  bus clock
- rst  input  1  asynchronous active-high reset
- dvalid  input  1  device request valid
- dready  output  1  port idle, can accept a request
- dmode  input  1  0 = read, 1 = write
- daddr  input  ADDR_WIDTH  request address
- dwdata  input  DATA_WIDTH  write data
- drdata  output  DATA_WIDTH  last read data
- ddone  output  1  one-cycle completion pulse
- derr  output  1  valid with ddone; 1 = read timeout
- mbreq  output  1  bus request to arbiter
- mbgrant  input  1  bus grant from arbiter
- mwdata  output  1  serial address/write data to slave
- mrdata  input  1  serial read data from slave
- mmode  output  1  0 = read, 1 = write, to slave
- mvalid  output  1  mwdata valid
- svalid  input  1  mrdata valid
- sready  input  1  slave ready for a transaction
- ssplit  input  1  slave has split the transaction

Behaviour:
- Reset (async, any state): state IDLE; mbreq, mvalid, mwdata, mmode, ddone, derr = 0; drdata = 0; counters = 0; dready = 1. Takes effect immediately, including mid-transfer.
- Serial bit order is LSB first for both address and data.
- dready = 1 only in IDLE.
- IDLE: on dvalid, latch daddr/dwdata/dmode; next cycle is REQ with mbreq = 1 and mmode = latched mode.
- REQ: wait for mbgrant & sready in the same cycle, then go to ADDR.
- ADDR: ADDR_WIDTH consecutive cycles with mvalid = 1 and mwdata = addr[bitcnt].
  - After the last bit, a write goes to WDATA with no gap cycle.
  - After the last bit, a read goes to RWAIT.
- WDATA: DATA_WIDTH consecutive cycles with mvalid = 1 and mwdata = wdata[bitcnt]; then DONE.
- RWAIT: mvalid = 0.
  - On the first cycle with svalid = 1, sample mrdata as bit 0 and go to RDATA.
  - The timeout counter counts cycles with svalid = 0 and ssplit = 0; it is cleared while ssplit = 1.
  - If the counter reaches TIMEOUT (TIMEOUT ≠ 0), go to DONE with derr = 1; drdata is left unchanged.
- RDATA: shift in mrdata only on cycles with svalid = 1; svalid gaps pause the shift and do not abort. After DATA_WIDTH bits, update drdata and go to DONE.
- Split: while ssplit = 1, the port holds mbreq and keeps waiting. Split release is the arbiter's responsibility.
- DONE (1 cycle): ddone = 1, derr valid, mbreq = 0, mmode = 0; next cycle is IDLE.
- A dvalid asserted during DONE is ignored (dready = 0).
- mbgrant dropping after ADDR has started is ignored; the arbiter guarantees the grant is held.
- Latency with grant and sready already high (request accepted in cycle 0):
  - first address bit on the bus in cycle 2;
  - write: ddone in cycle 2 + ADDR_WIDTH + DATA_WIDTH;
  - read: ddone one cycle after the last svalid bit.
- The bit counter is clog2(max(ADDR_WIDTH, DATA_WIDTH)) bits wide and never wraps within a phase.

Decomposition:
- Shared package bus_pkg:
  - state enum (IDLE, REQ, ADDR, WDATA, RWAIT, RDATA, DONE);
  - MODE_READ = 0 and MODE_WRITE = 1 constants;
  - default width constants shared with slave_port.
- One sub-module, serial_shift_reg: parallel-load/shift-out plus shift-in register with bit counter and last-bit flag. It is instantiated once and reused for the address, write-data and read-data phases.

Test Plan:
- Write, ADDR_WIDTH = 12, DATA_WIDTH = 8, grant and sready high: daddr = 0x0A5, dwdata = 0x3C, dmode = 1.
  - mvalid high for cycles 2–21; mwdata sequence is 1,0,1,0,0,1,0,1,0,0,0,0 then 0,0,1,1,1,1,0,0.
  - ddone in cycle 22, derr = 0.
- Read: daddr = 0x7FF; slave raises svalid 5 cycles after the last address bit and sends 0x81 LSB first → drdata = 0x81, ddone, derr = 0.
- Read with svalid gaps: svalid toggles 1,0,1,… while sending 0xA6 → drdata = 0xA6; ddone only after 8 valid bits.
- Timeout, TIMEOUT = 64: svalid never asserted → ddone with derr = 1 exactly 64 cycles after entering RWAIT; drdata unchanged.
- Split plus late grant: mbgrant delayed 10 cycles → no mvalid before grant. ssplit held 200 cycles during RWAIT, then 0x55 sent → no timeout, drdata = 0x55.
- Reset asserted mid-WDATA → all outputs reach their reset values without waiting for a clock edge. After release, dready = 1, and a new write completes normally.
